rf_write_arbiter: RTL and testbench

//  Owns the single register-file write port (Dest_wb/Result_WB/writeBackEn).

---
 rtl/rf_write_arbiter_pkg.sv | 32 +++
 rtl/rf_aux_buffer.sv | 33 +++
 rtl/rf_write_arbiter.sv | 118 +++++++++++
 tb/tb_rf_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: index/data widths,
// the write request record and the grant encoding.
package rf_write_arbiter_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic                 en;
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    value;
    } wr_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_AUX  = 2'd2
    } grant_e;

    function automatic wr_req_t make_req(
        input logic                 en,
        input logic [REG_IDX_W-1:0] dest,
        input logic [DATA_W-1:0]    value
    );
        wr_req_t req;
        req.en    = en;
        req.dest  = dest;
        req.value = value;
        return req;
    endfunction

endpackage

// File: rtl/rf_aux_buffer.sv
// One-entry holding register for the auxiliary write requester. Accepts only
// while empty; emptied when the arbiter grants it or a younger write supersedes it.
module rf_aux_buffer
    import rf_write_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [REG_IDX_W-1:0] i_dest,
    input  logic [DATA_W-1:0]    i_value,
    input  logic                 i_pop,
    input  logic                 i_flush,
    output wr_req_t              o_entry
);

    wr_req_t r_entry;

    // Pop and flush can only occur while full, so they never collide with a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry <= '0;
        end else if (i_pop || i_flush) begin
            r_entry.en <= 1'b0;
        end else if (i_valid && !r_entry.en) begin
            r_entry <= make_req(1'b1, i_dest, i_value);
        end
    end

    assign o_ready = ~r_entry.en;
    assign o_entry = r_entry;

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the single register-file write port, sharing it between the pipeline WB
// stage (priority) and one buffered auxiliary requester with starvation relief.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int NREG     = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]    wb_value,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [REG_IDX_W-1:0] aux_dest,
    input  logic [DATA_W-1:0]    aux_value,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    output logic                 hazard,
    output logic                 wb_stall,
    output logic [REG_IDX_W-1:0] Dest_wb,
    output logic [DATA_W-1:0]    Result_WB,
    output logic                 writeBackEn
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    wr_req_t              w_buf;
    wr_req_t              w_grantReq;
    grant_e               w_grant;
    logic                 w_pop;
    logic                 w_supersede;
    logic                 w_bufValidNext;
    logic [3:0]           w_starveNext;
    logic [NREG-1:0]      w_pendingMask;
    logic [NREG-1:0]      w_srcMask;

    logic                 r_wbStall;
    logic [3:0]           r_starveCnt;
    logic [REG_IDX_W-1:0] r_dest;
    logic [DATA_W-1:0]    r_value;
    logic                 r_wrEn;

    rf_aux_buffer u_auxBuffer (
        .clk     (clk),
        .rst     (rst),
        .i_valid (aux_valid),
        .o_ready (aux_ready),
        .i_dest  (aux_dest),
        .i_value (aux_value),
        .i_pop   (w_pop),
        .i_flush (w_supersede),
        .o_entry (w_buf)
    );

    // A raised stall means the pipeline has been told to hold, so its request is ignored.
    always_comb begin
        w_grant = GRANT_NONE;
        if (r_wbStall && w_buf.en) begin
            w_grant = GRANT_AUX;
        end else if (wb_en) begin
            w_grant = GRANT_WB;
        end else if (w_buf.en) begin
            w_grant = GRANT_AUX;
        end
    end

    always_comb begin
        w_grantReq = make_req(1'b0, r_dest, r_value);
        case (w_grant)
            GRANT_WB:  w_grantReq = make_req(1'b1, wb_dest, wb_value);
            GRANT_AUX: w_grantReq = make_req(1'b1, w_buf.dest, w_buf.value);
            default:   w_grantReq = make_req(1'b0, r_dest, r_value);
        endcase
    end

    assign w_pop          = (w_grant == GRANT_AUX);
    assign w_supersede    = (w_grant == GRANT_WB) && w_buf.en && (wb_dest == w_buf.dest);
    assign w_bufValidNext = (aux_valid && aux_ready) || (w_buf.en && !w_pop && !w_supersede);

    always_comb begin
        w_starveNext = 4'd0;
        if (w_buf.en && (w_grant == GRANT_WB) && !w_supersede) begin
            w_starveNext = (r_starveCnt == MaxWait) ? r_starveCnt : r_starveCnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbStall   <= 1'b0;
            r_starveCnt <= 4'd0;
            r_wrEn      <= 1'b0;
            r_dest      <= '0;
            r_value     <= '0;
        end else begin
            r_wbStall   <= (w_starveNext == MaxWait) && w_bufValidNext;
            r_starveCnt <= w_starveNext;
            r_wrEn      <= w_grantReq.en;
            if (w_grantReq.en) begin
                r_dest  <= w_grantReq.dest;
                r_value <= w_grantReq.value;
            end
        end
    end

    // In-flight pipeline writes are the forwarding unit's concern, not ours.
    assign w_pendingMask = w_buf.en ? (NREG'(1) << w_buf.dest) : '0;
    assign w_srcMask     = (NREG'(1) << src1) | (NREG'(1) << src2);
    assign hazard        = |(w_pendingMask & w_srcMask);

    assign wb_stall    = r_wbStall;
    assign Dest_wb     = r_dest;
    assign Result_WB   = r_value;
    assign writeBackEn = r_wrEn;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued as stimulus is
// driven and matched in order against every writeBackEn pulse.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] value;
    } expWrite_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        aux_valid;
    logic        aux_ready;
    logic [3:0]  aux_dest;
    logic [31:0] aux_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard;
    logic        wb_stall;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic        writeBackEn;

    expWrite_t   sbQueue[$];
    logic [31:0] regFile [16];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.MAX_WAIT(4), .NREG(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .aux_dest    (aux_dest),
        .aux_value   (aux_value),
        .src1        (src1),
        .src2        (src2),
        .hazard      (hazard),
        .wb_stall    (wb_stall),
        .Dest_wb     (Dest_wb),
        .Result_WB   (Result_WB),
        .writeBackEn (writeBackEn)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wbEn, input logic [3:0] wbDest, input logic [31:0] wbValue,
                                 input logic auxValid, input logic [3:0] auxDest, input logic [31:0] auxValue);
        wb_en     = wbEn;
        wb_dest   = wbDest;
        wb_value  = wbValue;
        aux_valid = auxValid;
        aux_dest  = auxDest;
        aux_value = auxValue;
    endtask

    task automatic expectWrite(input logic [3:0] dest, input logic [31:0] value);
        expWrite_t e;
        e.dest  = dest;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register file model commits on the negedge; every write must match the queue head.
    always @(negedge clk) begin
        if (!rst && writeBackEn) begin
            regFile[Dest_wb] = Result_WB;
            checkOutput("sb_write_expected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                expWrite_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_dest", {28'd0, Dest_wb}, {28'd0, e.dest});
                checkOutput("sb_value", Result_WB, e.value);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regFile[i] = 32'd0;
        rst = 1'b1;
        src1 = 4'd0;
        src2 = 4'd0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        $display("[TB] reset and idle");
        checkOutput("reset_dest", {28'd0, Dest_wb}, 32'd0);
        checkOutput("reset_result", Result_WB, 32'd0);
        checkOutput("reset_wben", {31'd0, writeBackEn}, 32'd0);
        checkOutput("reset_stall", {31'd0, wb_stall}, 32'd0);
        checkOutput("reset_aux_ready", {31'd0, aux_ready}, 32'd1);
        checkOutput("reset_hazard", {31'd0, hazard}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_wben", {31'd0, writeBackEn}, 32'd0);
        end

        $display("[TB] pipeline write");
        applyStimulus(1'b1, 4'd3, 32'hA5, 1'b0, 4'd0, 32'd0);
        expectWrite(4'd3, 32'hA5);
        tick();
        checkOutput("t2_wben", {31'd0, writeBackEn}, 32'd1);
        checkOutput("t2_dest", {28'd0, Dest_wb}, 32'd3);
        checkOutput("t2_result", Result_WB, 32'hA5);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t2_rf_r3", regFile[3], 32'hA5);
        tick();

        $display("[TB] aux write on idle port");
        src1 = 4'd7;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h1234);
        checkOutput("t3_ready_before", {31'd0, aux_ready}, 32'd1);
        checkOutput("t3_hazard_before", {31'd0, hazard}, 32'd0);
        expectWrite(4'd7, 32'h1234);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checkOutput("t3_ready_full", {31'd0, aux_ready}, 32'd0);
        checkOutput("t3_hazard_src1", {31'd0, hazard}, 32'd1);
        checkOutput("t3_no_write_accept", {31'd0, writeBackEn}, 32'd0);
        src1 = 4'd0;
        src2 = 4'd7;
        #1;
        checkOutput("t3_hazard_src2", {31'd0, hazard}, 32'd1);
        src2 = 4'd0;
        #1;
        checkOutput("t3_hazard_clear", {31'd0, hazard}, 32'd0);
        tick();
        checkOutput("t3_wben", {31'd0, writeBackEn}, 32'd1);
        checkOutput("t3_dest", {28'd0, Dest_wb}, 32'd7);
        checkOutput("t3_result", Result_WB, 32'h1234);
        checkOutput("t3_ready_after", {31'd0, aux_ready}, 32'd1);
        tick();
        checkOutput("t3_idle_after", {31'd0, writeBackEn}, 32'd0);

        $display("[TB] aux starvation under continuous pipeline writes");
        applyStimulus(1'b1, 4'd2, 32'h200, 1'b1, 4'd7, 32'h7777);
        expectWrite(4'd2, 32'h200);
        tick();
        checkOutput("t4_ready_full", {31'd0, aux_ready}, 32'd0);
        checkOutput("t4_stall_accept", {31'd0, wb_stall}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 4'd2, 32'h200 + 32'(k), 1'b0, 4'd0, 32'd0);
            expectWrite(4'd2, 32'h200 + 32'(k));
            tick();
            checkOutput("t4_stall", {31'd0, wb_stall}, (k == 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 4'd2, 32'h205, 1'b0, 4'd0, 32'd0);
        expectWrite(4'd7, 32'h7777);
        tick();
        checkOutput("t4_stall_released", {31'd0, wb_stall}, 32'd0);
        checkOutput("t4_aux_dest", {28'd0, Dest_wb}, 32'd7);
        checkOutput("t4_ready_after", {31'd0, aux_ready}, 32'd1);
        expectWrite(4'd2, 32'h205);
        tick();
        checkOutput("t4_resume_dest", {28'd0, Dest_wb}, 32'd2);
        checkOutput("t4_resume_value", Result_WB, 32'h205);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        checkOutput("t4_idle_after", {31'd0, writeBackEn}, 32'd0);

        $display("[TB] pipeline supersedes buffered aux");
        src1 = 4'd5;
        applyStimulus(1'b1, 4'd1, 32'h11, 1'b1, 4'd5, 32'h55);
        expectWrite(4'd1, 32'h11);
        tick();
        checkOutput("t5_hazard", {31'd0, hazard}, 32'd1);
        checkOutput("t5_ready_full", {31'd0, aux_ready}, 32'd0);
        applyStimulus(1'b1, 4'd5, 32'h99, 1'b0, 4'd0, 32'd0);
        expectWrite(4'd5, 32'h99);
        tick();
        checkOutput("t5_dest", {28'd0, Dest_wb}, 32'd5);
        checkOutput("t5_result", Result_WB, 32'h99);
        checkOutput("t5_ready_freed", {31'd0, aux_ready}, 32'd1);
        checkOutput("t5_hazard_clear", {31'd0, hazard}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("t5_no_aux_write", {31'd0, writeBackEn}, 32'd0);
        end
        @(negedge clk);
        #1;
        checkOutput("t5_rf_r5", regFile[5], 32'h99);
        tick();

        $display("[TB] asynchronous reset with aux buffered");
        src1 = 4'd9;
        applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd9, 32'h9999);
        expectWrite(4'd4, 32'h44);
        tick();
        checkOutput("t6_hazard", {31'd0, hazard}, 32'd1);
        applyStimulus(1'b1, 4'd4, 32'h45, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_wben", {31'd0, writeBackEn}, 32'd0);
        checkOutput("t6_rst_dest", {28'd0, Dest_wb}, 32'd0);
        checkOutput("t6_rst_result", Result_WB, 32'd0);
        checkOutput("t6_rst_ready", {31'd0, aux_ready}, 32'd1);
        checkOutput("t6_rst_hazard", {31'd0, hazard}, 32'd0);
        checkOutput("t6_rst_stall", {31'd0, wb_stall}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_no_write_after", {31'd0, writeBackEn}, 32'd0);
            checkOutput("t6_ready_after", {31'd0, aux_ready}, 32'd1);
        end

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
